// File: rtl/fan_pwm_ramp.sv
// Soft-start PWM fan motor driver.
// A requested fan level maps to a target duty. The applied duty walks toward
// that target in bounded steps, and steps only at PWM period boundaries, so
// the motor never sees a current surge or a truncated pulse.
module fan_pwm_ramp #(
    parameter int CLK_DIV      = 100,
    parameter int PWM_PERIOD   = 1000,
    parameter int RAMP_PERIODS = 10,
    parameter int DUTY_STEP    = 10
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [2:0] i_fanState,
    output logic       o_motor,
    output logic [9:0] o_duty,
    output logic       o_ramping
);

    // Counter widths. Clamp to 1 bit so a divide-by-1 or a
    // one-period ramp still gives a legal vector.
    localparam int PRE_W  = (CLK_DIV > 1)      ? $clog2(CLK_DIV)      : 1;
    localparam int STEP_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_DIV - 1);
    localparam logic [9:0]        PWM_LAST  = 10'(PWM_PERIOD - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(RAMP_PERIODS - 1);
    localparam logic [9:0]        STEP_SIZE = 10'(DUTY_STEP);

    logic [PRE_W-1:0]  prescale_r;
    logic [9:0]        pwm_cnt_r;
    logic [STEP_W-1:0] step_cnt_r;
    logic [9:0]        duty_r;
    logic              motor_r;

    logic [9:0]        target_s;
    logic              tick_s;
    logic              period_end_s;
    logic              at_target_s;
    logic              step_event_s;
    logic [9:0]        up_diff_s;
    logic [9:0]        down_diff_s;
    logic [9:0]        duty_next_s;

    // Map the requested fan level to its target duty; unused codes mean off.
    always_comb begin
        target_s = 10'd0;
        case (i_fanState)
            3'd0:    target_s = 10'd0;
            3'd1:    target_s = 10'd200;
            3'd2:    target_s = 10'd400;
            3'd3:    target_s = 10'd600;
            3'd4:    target_s = 10'd800;
            default: target_s = 10'd0;
        endcase
    end

    assign tick_s       = (prescale_r == PRE_LAST);
    assign period_end_s = tick_s && (pwm_cnt_r == PWM_LAST);
    assign at_target_s  = (duty_r == target_s);
    assign step_event_s = period_end_s && (step_cnt_r == STEP_LAST) && !at_target_s;

    // Next duty on a step: move toward the target by at most one step, and
    // subtract only in the direction that cannot wrap below zero.
    always_comb begin
        up_diff_s   = 10'd0;
        down_diff_s = 10'd0;
        duty_next_s = duty_r;
        if (duty_r < target_s) begin
            up_diff_s = target_s - duty_r;
            if (up_diff_s > STEP_SIZE) begin
                duty_next_s = duty_r + STEP_SIZE;
            end else begin
                duty_next_s = target_s;
            end
        end else if (duty_r > target_s) begin
            down_diff_s = duty_r - target_s;
            if (down_diff_s > STEP_SIZE) begin
                duty_next_s = duty_r - STEP_SIZE;
            end else begin
                duty_next_s = target_s;
            end
        end else begin
            duty_next_s = duty_r;
        end
    end

    // Clock prescaler producing one count tick every CLK_DIV cycles.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            prescale_r <= {PRE_W{1'b0}};
        end else if (tick_s) begin
            prescale_r <= {PRE_W{1'b0}};
        end else begin
            prescale_r <= prescale_r + PRE_W'(1);
        end
    end

    // PWM period counter, advancing on ticks only.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            pwm_cnt_r <= 10'd0;
        end else if (tick_s) begin
            if (pwm_cnt_r == PWM_LAST) begin
                pwm_cnt_r <= 10'd0;
            end else begin
                pwm_cnt_r <= pwm_cnt_r + 10'd1;
            end
        end else begin
            pwm_cnt_r <= pwm_cnt_r;
        end
    end

    // Ramp pacing: count period ends while off target; parked at zero on
    // target so a new target always waits a full RAMP_PERIODS interval.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            step_cnt_r <= {STEP_W{1'b0}};
        end else if (at_target_s) begin
            step_cnt_r <= {STEP_W{1'b0}};
        end else if (period_end_s) begin
            if (step_cnt_r == STEP_LAST) begin
                step_cnt_r <= {STEP_W{1'b0}};
            end else begin
                step_cnt_r <= step_cnt_r + STEP_W'(1);
            end
        end else begin
            step_cnt_r <= step_cnt_r;
        end
    end

    // Applied duty, updated only on a step (always a period boundary).
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            duty_r <= 10'd0;
        end else if (step_event_s) begin
            duty_r <= duty_next_s;
        end else begin
            duty_r <= duty_r;
        end
    end

    // Registered motor drive; a zero duty keeps the output permanently low.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            motor_r <= 1'b0;
        end else begin
            motor_r <= (pwm_cnt_r < duty_r);
        end
    end

    assign o_motor   = motor_r;
    assign o_duty    = duty_r;
    assign o_ramping = !at_target_s;

endmodule

// File: tb/tb_fan_pwm_ramp.sv
// Directed bench for fan_pwm_ramp.
// Three instances share one clock:
//   dut_a    : PWM_PERIOD=1000, RAMP_PERIODS=2, DUTY_STEP=10  (main behaviour)
//   dut_b    : as dut_a but DUTY_STEP=300                     (clamp, ramp to off)
//   dut_c    : PWM_PERIOD=20 short period                     (long ramps, reset mid-ramp)
// Every instance has CLK_DIV=1, so one PWM period is PWM_PERIOD clocks and
// periods restart at the first rising edge after reset release.
module tb_fan_pwm_ramp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_main_n;
    logic       rst_fast_n;
    logic [2:0] fan_a, fan_b, fan_c;
    logic       motor_a, motor_b, motor_c;
    logic [9:0] duty_a, duty_b, duty_c;
    logic       ramp_a, ramp_b, ramp_c;

    fan_pwm_ramp #(.CLK_DIV(1), .PWM_PERIOD(1000), .RAMP_PERIODS(2), .DUTY_STEP(10)) dut_a (
        .i_clk(clk), .i_reset(rst_main_n), .i_fanState(fan_a),
        .o_motor(motor_a), .o_duty(duty_a), .o_ramping(ramp_a));

    fan_pwm_ramp #(.CLK_DIV(1), .PWM_PERIOD(1000), .RAMP_PERIODS(2), .DUTY_STEP(300)) dut_b (
        .i_clk(clk), .i_reset(rst_main_n), .i_fanState(fan_b),
        .o_motor(motor_b), .o_duty(duty_b), .o_ramping(ramp_b));

    fan_pwm_ramp #(.CLK_DIV(1), .PWM_PERIOD(20), .RAMP_PERIODS(2), .DUTY_STEP(10)) dut_c (
        .i_clk(clk), .i_reset(rst_fast_n), .i_fanState(fan_c),
        .o_motor(motor_c), .o_duty(duty_c), .o_ramping(ramp_c));

    int n_compared    = 0;
    int n_mismatched  = 0;
    int cnt_a, cnt_b, cnt_c;
    int total_cycles  = 0;

    int w_exp [6] = '{400, 400, 100, 100, 0, 0};
    int d_exp [6] = '{400, 100, 100, 0, 0, 0};

    // Single comparison point: count it, report any mismatch.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clocks, sampling each motor output on the falling edge.
    task automatic run_cycles(input int n);
        cnt_a = 0;
        cnt_b = 0;
        cnt_c = 0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            cnt_a += int'(motor_a);
            cnt_b += int'(motor_b);
            cnt_c += int'(motor_c);
        end
        total_cycles += n;
    endtask

    initial begin
        fan_a      = 3'd0;
        fan_b      = 3'd0;
        fan_c      = 3'd4;
        rst_main_n = 1'b0;
        rst_fast_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);

        // Reset state
        check_val("rst_duty_a",  duty_a,  0);
        check_val("rst_motor_a", motor_a, 0);
        check_val("rst_ramp_a",  ramp_a,  0);
        check_val("rst_duty_c",  duty_c,  0);
        check_val("rst_motor_c", motor_c, 0);
        check_val("rst_ramp_c",  ramp_c,  1);
        rst_main_n = 1'b1;
        rst_fast_n = 1'b1;

        // Idle at level 0 for 10 periods
        run_cycles(10000);
        check_val("off_width_a", cnt_a,  0);
        check_val("off_duty_a",  duty_a, 0);
        check_val("off_ramp_a",  ramp_a, 0);
        // dut_c ramped 0 -> 800 in 160 short periods meanwhile
        check_val("up800_duty_c", duty_c, 800);
        check_val("up800_ramp_c", ramp_c, 0);

        // Level 0 -> 1 on dut_a
        fan_a = 3'd1;
        #1;
        check_val("lvl1_ramp_now", ramp_a, 1);
        run_cycles(2000);
        check_val("lvl1_width_p12", cnt_a,  0);
        check_val("lvl1_duty_2pe",  duty_a, 10);
        run_cycles(2000);
        check_val("lvl1_width_p34", cnt_a,  20);
        check_val("lvl1_duty_4pe",  duty_a, 20);
        run_cycles(36000);
        check_val("lvl1_duty_40pe", duty_a, 200);
        check_val("lvl1_ramp_done", ramp_a, 0);
        run_cycles(1000);
        check_val("lvl1_width_200", cnt_a,  200);
        check_val("lvl1_duty_hold", duty_a, 200);

        // 800 -> level 1 on dut_c: down by 10 every 2 periods
        fan_c = 3'd1;
        #1;
        check_val("down_ramp_now", ramp_c, 1);
        for (int k = 1; k <= 60; k++) begin
            run_cycles(40);
            check_val($sformatf("down_step%0d", k), duty_c, 800 - 10 * k);
        end
        run_cycles(200);
        check_val("down_floor_duty", duty_c, 200);
        check_val("down_floor_ramp", ramp_c, 0);

        // Realign to a 1000-clock period boundary for dut_b
        if ((total_cycles % 1000) != 0) begin
            run_cycles(1000 - (total_cycles % 1000));
        end

        // DUTY_STEP=300: 0 -> 300 -> 400 with clamp
        fan_b = 3'd2;
        #1;
        check_val("clamp_ramp_now", ramp_b, 1);
        run_cycles(2000);
        check_val("clamp_width_p12", cnt_b,  0);
        check_val("clamp_duty_300",  duty_b, 300);
        run_cycles(2000);
        check_val("clamp_width_p34", cnt_b,  600);
        check_val("clamp_duty_400",  duty_b, 400);
        check_val("clamp_ramp_done", ramp_b, 0);
        run_cycles(2000);
        check_val("clamp_width_hold", cnt_b,  800);
        check_val("clamp_no_over",    duty_b, 400);

        // Unused level 6 from 400: ramp to off, width per period
        fan_b = 3'd6;
        #1;
        check_val("lvl6_ramp_now", ramp_b, 1);
        for (int p = 0; p < 6; p++) begin
            run_cycles(1000);
            check_val($sformatf("lvl6_width_p%0d", p), cnt_b,  w_exp[p]);
            check_val($sformatf("lvl6_duty_p%0d", p),  duty_b, d_exp[p]);
        end
        check_val("lvl6_ramp_done", ramp_b, 0);

        // Reset pulse mid-ramp on dut_c (200 -> 0, then up to 100)
        fan_c = 3'd0;
        run_cycles(800);
        check_val("mid_down_zero", duty_c, 0);
        fan_c = 3'd1;
        run_cycles(400);
        check_val("mid_duty_100",  duty_c,  100);
        check_val("mid_motor_on",  motor_c, 1);
        rst_fast_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("mid_rst_duty",  duty_c,  0);
        check_val("mid_rst_motor", motor_c, 0);
        check_val("mid_rst_ramp",  ramp_c,  1);
        rst_fast_n = 1'b1;
        run_cycles(40);
        check_val("resume_duty_10", duty_c, 10);
        run_cycles(40);
        check_val("resume_duty_20", duty_c, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
